accel_host_arbiter: RTL and testbench
=====================================

# accel_host_arbiter

Two-port host arbiter placed in front of `Accelerator`. It shares the accelerator's single write (configuration) port and single read port between host requesters M0 and M1. Writes and reads are sequenced independently, each with round-robin arbitration and registered outputs toward the accelerator. Read data is routed back to the requester that issued the read. An optional watchdog terminates read responses that never arrive.

## Interface

- `ADDR_W`, 32, address width; must equal the `AddrBus` width in `global.vh`.
- `DATA_W`, 32, data width; must equal the `DataBus` width in `global.vh`.
- `TIMEOUT`, 1024, read-response watchdog limit in cycles; used only with `ARB_TIMEOUT_EN`.

Ports:

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `m_write_en`  in  2  per-requester write enable; bit i belongs to Mi.
- `m_write_rdy`  out  2  per-requester write ready.
- `m_write_addr`  in  2×ADDR_W  per-requester write address.
- `m_write_data`  in  2×DATA_W  per-requester write data.
- `m_read_en`  in  2  per-requester read enable.
- `m_read_rdy`  out  2  per-requester read ready.
- `m_read_addr`  in  2×ADDR_W  per-requester read address.
- `m_read_data_rdy`  in  2  requester can accept read data.
- `m_read_data_vld`  out  2  read data valid toward the requester.
- `m_read_data`  out  DATA_W  read data, shared by both requesters; qualify with `m_read_data_vld`.
- `write_en`, `write_rdy`, `write_addr`, `write_data`  out/in/out/out  1/1/ADDR_W/DATA_W  accelerator write port.
- `read_en`, `read_rdy`, `read_addr`  out/in/out  1/1/ADDR_W  accelerator read request port.
- `read_data_rdy`, `read_data_vld`, `read_data`  out/in/in  1/1/DATA_W  accelerator read data port.
- `rd_timeout`  out  1  sticky watchdog flag; exists only with `ARB_TIMEOUT_EN`.

## Operation

- **Handshake rule:** every channel transfers on a cycle where en/vld && rdy at the rising edge.
- **Write FSM states:** W_IDLE, W_ISSUE.
  - In W_IDLE: `m_write_rdy[i] = !m_write_en[1-i] || wr_pref==i`. A requester's ready never depends on its own enable.
  - On accept: latch addr/data, record the winner, set `wr_pref` to the other requester, go to W_ISSUE.
  - In W_ISSUE: hold `write_en=1` with stable addr/data until `write_rdy=1` at an edge, then return to W_IDLE. `m_write_rdy` is 0 throughout.
- **Read FSM states:** R_IDLE, R_ISSUE, R_RESP.
  - R_IDLE arbitrates exactly like the write FSM, using a separate `rd_pref` and recording `rd_owner`.
  - R_ISSUE holds `read_en`/`read_addr` until `read_rdy`, then moves to R_RESP.
  - R_RESP: `m_read_data_vld[rd_owner] = read_data_vld` and `read_data_rdy = m_read_data_rdy[rd_owner]`, both combinational pass-through. `m_read_data = read_data`.
  - R_RESP returns to R_IDLE on the data handshake.
- Only one read is outstanding at a time. The read and write FSMs run fully concurrently.
- `read_data_vld` arriving outside R_RESP is ignored, and `read_data_rdy` is 0 outside R_RESP.
- Reset sets `wr_pref=rd_pref=0`, so M0 wins the first tie.

## Timing

- **Reset values:** `m_write_rdy=2'b11`, `m_read_rdy=2'b11`; `write_en=read_en=read_data_rdy=0`; addr/data outputs 0; `m_read_data_vld=0`; `rd_timeout=0`. FSMs enter W_IDLE/R_IDLE.
- **Write latency:** accept at edge N gives `write_en=1` in cycle N+1. If `write_rdy` is already high, the transfer completes at edge N+1. The next accept is possible at edge N+2, so throughput is 1 write per 2 cycles.
- **Read latency:** accept at N gives `read_en` in N+1. Response forwarding starts in R_RESP with zero added cycles.
- **Simultaneous requests:** with both enables high in IDLE, only `m_*_rdy[pref]` is high; the loser is granted on the next idle cycle.
- **Reset mid-operation:** asserting `rst_n` low immediately drops `write_en`/`read_en` and abandons any pending transfer without replay.

## Configuration

- **Macro:** `ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to R_RESP and increments each cycle in R_RESP without `read_data_vld`.
  - On reaching `TIMEOUT` it forces `m_read_data_vld[rd_owner]=1` with `m_read_data=32'hDEAD_BEEF`.
  - When the owner accepts, the FSM returns to R_IDLE and sets sticky `rd_timeout`, which only reset clears.
- **Undefined:** no counter and no `rd_timeout` port; R_RESP waits indefinitely.

## Test plan

- **Reset:** hold `rst_n=0` for 2 cycles -> all outputs at reset values; `m_write_rdy=2'b11`.
- **Single write:** M0 writes addr 0x10, data 0x1234_5678 with `write_rdy=1` -> `write_en` high exactly 1 cycle at N+1 with the same addr/data.
- **Tie:** both requesters write in the same cycle (M0 0x1/0xA, M1 0x2/0xB) -> M0's write issues first, then M1's. A second tie then grants M1 first.
- **Backpressure:** `write_rdy` is low for 5 cycles -> `write_en`/addr/data remain stable for all 5 cycles; `m_write_rdy=2'b00` throughout.
- **Read routing:** M1 reads 0x20, the accelerator returns 0xCAFE after 3 cycles, and M1 holds `m_read_data_rdy` low 2 cycles -> only `m_read_data_vld[1]` rises; the data is held stable until the handshake.
- **Watchdog (`ARB_TIMEOUT_EN`, TIMEOUT=8):** M0 reads and the accelerator never responds -> after 8 cycles M0 receives 0xDEAD_BEEF; `rd_timeout=1` and the read FSM returns to R_IDLE.

Source files
------------

// File: rtl/accel_host_arbiter_if.sv
// Host/accelerator bus bundle for accel_host_arbiter: two requester channels on the
// host side and the single write, read-request and read-data channels of the accelerator.
interface accel_host_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]             m_write_en;
    logic [1:0]             m_write_rdy;
    logic [1:0][ADDR_W-1:0] m_write_addr;
    logic [1:0][DATA_W-1:0] m_write_data;

    logic [1:0]             m_read_en;
    logic [1:0]             m_read_rdy;
    logic [1:0][ADDR_W-1:0] m_read_addr;
    logic [1:0]             m_read_data_rdy;
    logic [1:0]             m_read_data_vld;
    logic [DATA_W-1:0]      m_read_data;

    logic                   write_en;
    logic                   write_rdy;
    logic [ADDR_W-1:0]      write_addr;
    logic [DATA_W-1:0]      write_data;

    logic                   read_en;
    logic                   read_rdy;
    logic [ADDR_W-1:0]      read_addr;
    logic                   read_data_rdy;
    logic                   read_data_vld;
    logic [DATA_W-1:0]      read_data;

    // The arbiter's view of the bundle
    modport slave (
        input  m_write_en, m_write_addr, m_write_data,
        input  m_read_en, m_read_addr, m_read_data_rdy,
        input  write_rdy, read_rdy, read_data_vld, read_data,
        output m_write_rdy, m_read_rdy, m_read_data_vld, m_read_data,
        output write_en, write_addr, write_data,
        output read_en, read_addr, read_data_rdy
    );

    // The environment's view: host requesters plus the accelerator
    modport master (
        output m_write_en, m_write_addr, m_write_data,
        output m_read_en, m_read_addr, m_read_data_rdy,
        output write_rdy, read_rdy, read_data_vld, read_data,
        input  m_write_rdy, m_read_rdy, m_read_data_vld, m_read_data,
        input  write_en, write_addr, write_data,
        input  read_en, read_addr, read_data_rdy
    );
endinterface

// File: rtl/accel_host_arbiter.sv
// Two-requester round-robin arbiter sharing the accelerator's write and read ports.
// Define ARB_TIMEOUT_EN to add the read-response watchdog and the rd_timeout flag.
module accel_host_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    accel_host_arbiter_if.slave  bus
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                 rd_timeout
`endif
);

    typedef enum logic {W_IDLE, W_ISSUE} wrState_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} rdState_t;

    wrState_t          wrState_q, wrState_d;
    logic              wrPref_q, wrPref_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic [1:0]        wrReady, wrTake;

    rdState_t          rdState_q, rdState_d;
    logic              rdPref_q, rdPref_d;
    logic              rdOwner_q, rdOwner_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic [1:0]        rdReady, rdTake;
    logic              rdForced, respVld, respDone;

    // A requester is only held off when the other one also asks and holds the preference
    assign wrReady = (wrState_q == W_IDLE) ?
                     {(!bus.m_write_en[0] || wrPref_q), (!bus.m_write_en[1] || !wrPref_q)} : 2'b00;
    assign wrTake  = bus.m_write_en & wrReady;

    always_comb begin
        wrState_d = wrState_q;
        wrPref_d  = wrPref_q;
        wrAddr_d  = wrAddr_q;
        wrData_d  = wrData_q;
        case (wrState_q)
            W_IDLE: begin
                if (|wrTake) begin
                    wrAddr_d  = bus.m_write_addr[wrTake[1]];
                    wrData_d  = bus.m_write_data[wrTake[1]];
                    wrPref_d  = !wrTake[1];
                    wrState_d = W_ISSUE;
                end
            end
            W_ISSUE: begin
                if (bus.write_rdy) wrState_d = W_IDLE;
            end
            default: wrState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrState_q <= W_IDLE;
            wrPref_q  <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
        end else begin
            wrState_q <= wrState_d;
            wrPref_q  <= wrPref_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
        end
    end

    assign bus.m_write_rdy = wrReady;
    assign bus.write_en    = (wrState_q == W_ISSUE);
    assign bus.write_addr  = wrAddr_q;
    assign bus.write_data  = wrData_q;

    assign rdReady = (rdState_q == R_IDLE) ?
                     {(!bus.m_read_en[0] || rdPref_q), (!bus.m_read_en[1] || !rdPref_q)} : 2'b00;
    assign rdTake  = bus.m_read_en & rdReady;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] rdCnt_q, rdCnt_d;
    logic             rdTimeout_q, rdTimeout_d;

    // Counter saturates at the limit so the forced response stays up until the owner takes it
    always_comb begin
        rdCnt_d     = rdCnt_q;
        rdTimeout_d = rdTimeout_q | (rdForced && bus.m_read_data_rdy[rdOwner_q]);
        if (rdState_q == R_ISSUE && bus.read_rdy)
            rdCnt_d = '0;
        else if (rdState_q == R_RESP && !bus.read_data_vld && rdCnt_q != CNT_MAX)
            rdCnt_d = rdCnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdCnt_q     <= '0;
            rdTimeout_q <= 1'b0;
        end else begin
            rdCnt_q     <= rdCnt_d;
            rdTimeout_q <= rdTimeout_d;
        end
    end

    assign rdForced   = (rdState_q == R_RESP) && !bus.read_data_vld && (rdCnt_q == CNT_MAX);
    assign rd_timeout = rdTimeout_q;
`else
    assign rdForced = 1'b0;
`endif

    assign respVld  = (rdState_q == R_RESP) && (bus.read_data_vld || rdForced);
    assign respDone = respVld && bus.m_read_data_rdy[rdOwner_q];

    always_comb begin
        rdState_d = rdState_q;
        rdPref_d  = rdPref_q;
        rdOwner_d = rdOwner_q;
        rdAddr_d  = rdAddr_q;
        case (rdState_q)
            R_IDLE: begin
                if (|rdTake) begin
                    rdAddr_d  = bus.m_read_addr[rdTake[1]];
                    rdOwner_d = rdTake[1];
                    rdPref_d  = !rdTake[1];
                    rdState_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                if (bus.read_rdy) rdState_d = R_RESP;
            end
            R_RESP: begin
                if (respDone) rdState_d = R_IDLE;
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdState_q <= R_IDLE;
            rdPref_q  <= 1'b0;
            rdOwner_q <= 1'b0;
            rdAddr_q  <= '0;
        end else begin
            rdState_q <= rdState_d;
            rdPref_q  <= rdPref_d;
            rdOwner_q <= rdOwner_d;
            rdAddr_q  <= rdAddr_d;
        end
    end

    assign bus.m_read_rdy      = rdReady;
    assign bus.read_en         = (rdState_q == R_ISSUE);
    assign bus.read_addr       = rdAddr_q;
    assign bus.read_data_rdy   = (rdState_q == R_RESP) && bus.m_read_data_rdy[rdOwner_q];
    assign bus.m_read_data_vld = respVld ? (rdOwner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.m_read_data     = rdForced ? DATA_W'(32'hDEAD_BEEF) : bus.read_data;

endmodule

// File: tb/tb_accel_host_arbiter.sv
// Directed bench for accel_host_arbiter with write/read scoreboards.
// With ARB_TIMEOUT_EN defined it also exercises the watchdog (TIMEOUT=8).
module tb_accel_host_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wrTxn_t;

    typedef struct packed {
        logic [1:0]  vld;
        logic [31:0] data;
    } rdTxn_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     testsRun = 0;
    int     testsFailed = 0;
    wrTxn_t wrQ[$];
    rdTxn_t rdQ[$];

    always #5 clk = ~clk;

    accel_host_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_TIMEOUT_EN
    logic rd_timeout;
`endif

    accel_host_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_TIMEOUT_EN
        ,
        .rd_timeout (rd_timeout)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic [31:0] a1, input logic [31:0] d1);
        bus.m_write_en      = en;
        bus.m_write_addr[0] = a0;
        bus.m_write_data[0] = d0;
        bus.m_write_addr[1] = a1;
        bus.m_write_data[1] = d1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // Accelerator-side write monitor: every write handshake must match the oldest expected write
    always @(negedge clk) begin
        wrTxn_t expTxn;
        if (rst_n && bus.write_en && bus.write_rdy) begin
            checkOutput("wr_expected_pending", 64'(wrQ.size() != 0), 64'd1);
            if (wrQ.size() != 0) begin
                expTxn = wrQ.pop_front();
                checkOutput("wr_sb_addr_data", {bus.write_addr, bus.write_data}, {expTxn.addr, expTxn.data});
            end
        end
    end

    // Host-side read monitor: checks routing (which valid bit) and returned data
    always @(negedge clk) begin
        rdTxn_t expTxn;
        if (rst_n && (|(bus.m_read_data_vld & bus.m_read_data_rdy))) begin
            checkOutput("rd_expected_pending", 64'(rdQ.size() != 0), 64'd1);
            if (rdQ.size() != 0) begin
                expTxn = rdQ.pop_front();
                checkOutput("rd_sb_route_data", 64'({bus.m_read_data_vld, bus.m_read_data}),
                            64'({expTxn.vld, expTxn.data}));
            end
        end
    end

    initial begin
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.m_read_en       = 2'b00;
        bus.m_read_addr[0]  = 32'h0;
        bus.m_read_addr[1]  = 32'h0;
        bus.m_read_data_rdy = 2'b00;
        bus.write_rdy       = 1'b0;
        bus.read_rdy        = 1'b0;
        bus.read_data_vld   = 1'b0;
        bus.read_data       = 32'h0;

        // Reset values while rst_n is held low
        rst_n = 1'b0;
        repeat (2) cycle();
        checkOutput("rst_m_write_rdy", 64'(bus.m_write_rdy), 64'h3);
        checkOutput("rst_m_read_rdy", 64'(bus.m_read_rdy), 64'h3);
        checkOutput("rst_write_en", 64'(bus.write_en), 64'h0);
        checkOutput("rst_read_en", 64'(bus.read_en), 64'h0);
        checkOutput("rst_read_data_rdy", 64'(bus.read_data_rdy), 64'h0);
        checkOutput("rst_write_addr", 64'(bus.write_addr), 64'h0);
        checkOutput("rst_write_data", 64'(bus.write_data), 64'h0);
        checkOutput("rst_read_addr", 64'(bus.read_addr), 64'h0);
        checkOutput("rst_m_read_data_vld", 64'(bus.m_read_data_vld), 64'h0);
`ifdef ARB_TIMEOUT_EN
        checkOutput("rst_rd_timeout", 64'(rd_timeout), 64'h0);
`endif
        rst_n = 1'b1;
        cycle();

        // Single write from M0 with the accelerator always ready
        bus.write_rdy = 1'b1;
        applyStimulus(2'b01, 32'h10, 32'h1234_5678, 32'h0, 32'h0);
        wrQ.push_back('{addr: 32'h10, data: 32'h1234_5678});
        #1;
        checkOutput("single_m_write_rdy", 64'(bus.m_write_rdy), 64'h1);
        cycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("single_write_en", 64'(bus.write_en), 64'h1);
        checkOutput("single_write_addr", 64'(bus.write_addr), 64'h10);
        checkOutput("single_write_data", 64'(bus.write_data), 64'h1234_5678);
        checkOutput("single_issue_rdy", 64'(bus.m_write_rdy), 64'h0);
        cycle();
        checkOutput("single_write_en_drop", 64'(bus.write_en), 64'h0);
        checkOutput("single_idle_rdy", 64'(bus.m_write_rdy), 64'h3);

        // Read data offered while the read FSM is idle must not be forwarded
        bus.read_data_vld = 1'b1;
        bus.read_data     = 32'h99;
        #1;
        checkOutput("idle_rd_vld_ignored", 64'(bus.m_read_data_vld), 64'h0);
        checkOutput("idle_read_data_rdy", 64'(bus.read_data_rdy), 64'h0);
        bus.read_data_vld = 1'b0;

        // Tie after reset: M0 first, then M0 re-requests against pending M1 and M1 wins
        resetDut();
        applyStimulus(2'b11, 32'h1, 32'hA, 32'h2, 32'hB);
        wrQ.push_back('{addr: 32'h1, data: 32'hA});
        wrQ.push_back('{addr: 32'h2, data: 32'hB});
        #1;
        checkOutput("tie1_m_write_rdy", 64'(bus.m_write_rdy), 64'h1);
        cycle();
        applyStimulus(2'b11, 32'h3, 32'hC, 32'h2, 32'hB);
        wrQ.push_back('{addr: 32'h3, data: 32'hC});
        #1;
        checkOutput("tie1_write_en", 64'(bus.write_en), 64'h1);
        checkOutput("tie1_winner", 64'({bus.write_addr, bus.write_data}), {32'h1, 32'hA});
        checkOutput("tie1_issue_rdy", 64'(bus.m_write_rdy), 64'h0);
        cycle();
        checkOutput("tie2_m_write_rdy", 64'(bus.m_write_rdy), 64'h2);
        cycle();
        applyStimulus(2'b01, 32'h3, 32'hC, 32'h0, 32'h0);
        #1;
        checkOutput("tie2_winner", 64'({bus.write_addr, bus.write_data}), {32'h2, 32'hB});
        cycle();
        checkOutput("tie2_loser_rdy", 64'(bus.m_write_rdy), 64'h1);
        cycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("tie2_loser_write", 64'({bus.write_addr, bus.write_data}), {32'h3, 32'hC});
        cycle();
        checkOutput("tie_done_write_en", 64'(bus.write_en), 64'h0);

        // Backpressure: accelerator not ready for 5 cycles
        bus.write_rdy = 1'b0;
        applyStimulus(2'b10, 32'h0, 32'h0, 32'h40, 32'h55);
        wrQ.push_back('{addr: 32'h40, data: 32'h55});
        cycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_write_en", 64'(bus.write_en), 64'h1);
            checkOutput("bp_write_addr", 64'(bus.write_addr), 64'h40);
            checkOutput("bp_write_data", 64'(bus.write_data), 64'h55);
            checkOutput("bp_m_write_rdy", 64'(bus.m_write_rdy), 64'h0);
            if (i < 4) cycle();
        end
        bus.write_rdy = 1'b1;
        cycle();
        checkOutput("bp_release_write_en", 64'(bus.write_en), 64'h0);

        // Read routing: M1 reads, data arrives 3 cycles later, M1 stalls 2 cycles
        bus.read_rdy          = 1'b1;
        bus.m_read_en         = 2'b10;
        bus.m_read_addr[1]    = 32'h20;
        rdQ.push_back('{vld: 2'b10, data: 32'hCAFE});
        #1;
        checkOutput("rd_m_read_rdy", 64'(bus.m_read_rdy), 64'h3);
        cycle();
        bus.m_read_en = 2'b00;
        #1;
        checkOutput("rd_read_en", 64'(bus.read_en), 64'h1);
        checkOutput("rd_read_addr", 64'(bus.read_addr), 64'h20);
        checkOutput("rd_busy_rdy", 64'(bus.m_read_rdy), 64'h0);
        cycle();
        checkOutput("rd_read_en_drop", 64'(bus.read_en), 64'h0);
        checkOutput("rd_wait_vld", 64'(bus.m_read_data_vld), 64'h0);
        checkOutput("rd_wait_data_rdy", 64'(bus.read_data_rdy), 64'h0);
        cycle();
        cycle();
        bus.read_data_vld = 1'b1;
        bus.read_data     = 32'hCAFE;
        #1;
        checkOutput("rd_route_vld", 64'(bus.m_read_data_vld), 64'h2);
        checkOutput("rd_route_data", 64'(bus.m_read_data), 64'hCAFE);
        checkOutput("rd_stall_data_rdy", 64'(bus.read_data_rdy), 64'h0);
        cycle();
        checkOutput("rd_hold_vld", 64'(bus.m_read_data_vld), 64'h2);
        checkOutput("rd_hold_data", 64'(bus.m_read_data), 64'hCAFE);
        cycle();
        bus.m_read_data_rdy = 2'b10;
        #1;
        checkOutput("rd_pass_data_rdy", 64'(bus.read_data_rdy), 64'h1);
        cycle();
        bus.read_data_vld   = 1'b0;
        bus.m_read_data_rdy = 2'b00;
        #1;
        checkOutput("rd_done_vld", 64'(bus.m_read_data_vld), 64'h0);
        checkOutput("rd_done_rdy", 64'(bus.m_read_rdy), 64'h3);

        // Reset in the middle of a stalled write drops it without replay
        bus.write_rdy = 1'b0;
        applyStimulus(2'b01, 32'h77, 32'h88, 32'h0, 32'h0);
        cycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("midrst_write_en_pre", 64'(bus.write_en), 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_write_en", 64'(bus.write_en), 64'h0);
        checkOutput("midrst_write_addr", 64'(bus.write_addr), 64'h0);
        cycle();
        rst_n = 1'b1;
        bus.write_rdy = 1'b1;
        cycle();
        checkOutput("midrst_no_replay", 64'(bus.write_en), 64'h0);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: M0 reads, accelerator accepts the request but never answers
        bus.read_rdy       = 1'b1;
        bus.read_data_vld  = 1'b0;
        bus.m_read_en      = 2'b01;
        bus.m_read_addr[0] = 32'h30;
        rdQ.push_back('{vld: 2'b01, data: 32'hDEAD_BEEF});
        cycle();
        bus.m_read_en = 2'b00;
        cycle();
        for (int i = 0; i < 8; i++) begin
            checkOutput("wd_wait_vld", 64'(bus.m_read_data_vld), 64'h0);
            cycle();
        end
        checkOutput("wd_forced_vld", 64'(bus.m_read_data_vld), 64'h1);
        checkOutput("wd_forced_data", 64'(bus.m_read_data), 64'hDEAD_BEEF);
        checkOutput("wd_flag_before", 64'(rd_timeout), 64'h0);
        bus.m_read_data_rdy = 2'b01;
        cycle();
        bus.m_read_data_rdy = 2'b00;
        #1;
        checkOutput("wd_flag_set", 64'(rd_timeout), 64'h1);
        checkOutput("wd_back_idle", 64'(bus.m_read_rdy), 64'h3);
        checkOutput("wd_vld_clear", 64'(bus.m_read_data_vld), 64'h0);
        cycle();
        checkOutput("wd_flag_sticky", 64'(rd_timeout), 64'h1);
`endif

        cycle();
        checkOutput("wr_queue_drained", 64'(wrQ.size()), 64'h0);
        checkOutput("rd_queue_drained", 64'(rdQ.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
